// File: rtl/c_result_drain_if.sv
// Result-buffer read port and outbound result stream for the C result drain.
interface c_result_drain_if #(
  parameter int D_WIDTH  = 64,
  parameter int ADDR_WTH = 2
);
  logic                rd_en_out;
  logic [ADDR_WTH-1:0] rd_addr_out;
  logic [D_WIDTH-1:0]  rd_data_in;
  logic [D_WIDTH-1:0]  m_tdata;
  logic                m_tvalid;
  logic                m_tready;
  logic                m_tlast;

  modport master (
    output rd_en_out, rd_addr_out, m_tdata, m_tvalid, m_tlast,
    input  rd_data_in, m_tready
  );

  modport slave (
    input  rd_en_out, rd_addr_out, m_tdata, m_tvalid, m_tlast,
    output rd_data_in, m_tready
  );
endinterface

// File: rtl/c_result_drain.sv
// Drains each completed C tile from the double-buffered result store into a
// valid/ready stream, using a credit-limited output FIFO to absorb backpressure.
module c_result_drain #(
  parameter int D_WIDTH    = 64,
  parameter int ADDR_WTH   = 2,
  parameter int RD_DELAY   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             output_trigger_in,
  c_result_drain_if.master bus,
  output logic             busy,
  output logic             tile_done,
  output logic             overrun_err,
  output logic [15:0]      tile_count
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + RD_DELAY + 1);
  localparam logic [ADDR_WTH-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t              state, state_nxt;
  logic [ADDR_WTH-1:0] addr, addr_nxt;
  logic                pending, pending_nxt;
  logic                trig_q;
  logic                toggle;

  logic [RD_DELAY-1:0] rd_vld_p;
  logic [D_WIDTH-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    fifo_count;
  logic [CNT_W-1:0]    inflight;
  logic [ADDR_WTH-1:0] beat_cnt;

  logic rd_en, push, pop, fifo_empty, last_beat, drain_done;

  function automatic logic [CNT_W-1:0] popcount(input logic [RD_DELAY-1:0] v);
    logic [CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < RD_DELAY; i++) n = n + CNT_W'(v[i]);
    return n;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Any edge on the store's buffer index means one tile buffer was handed over.
  assign toggle     = output_trigger_in ^ trig_q;
  assign inflight   = popcount(rd_vld_p);
  assign fifo_empty = (fifo_count == '0);
  assign push       = rd_vld_p[RD_DELAY-1];
  assign pop        = !fifo_empty && bus.m_tready;
  assign last_beat  = !fifo_empty && (beat_cnt == LAST_ADDR);
  assign drain_done = (state == FLUSH) && pop && last_beat;

  // Only issue a read when a FIFO slot is guaranteed for its returning data.
  assign rd_en = (state == READ) &&
                 ((32'(fifo_count) + 32'(inflight)) < 32'(FIFO_DEPTH));

  assign bus.rd_en_out   = rd_en;
  assign bus.rd_addr_out = addr;
  assign bus.m_tvalid    = !fifo_empty;
  assign bus.m_tdata     = fifo_empty ? '0 : fifo_mem[rd_ptr];
  assign bus.m_tlast     = last_beat;
  assign busy            = (state != IDLE);

  always_comb begin
    state_nxt   = state;
    addr_nxt    = addr;
    pending_nxt = pending;
    case (state)
      IDLE: begin
        if (toggle) begin
          state_nxt = READ;
          addr_nxt  = '0;
        end
      end
      READ: begin
        if (rd_en) begin
          addr_nxt = addr + ADDR_WTH'(1);
          if (addr == LAST_ADDR) state_nxt = FLUSH;
        end
        if (toggle) pending_nxt = 1'b1;
      end
      FLUSH: begin
        if (drain_done) begin
          // A toggle landing on the completion edge chains straight into the next tile.
          if (pending || toggle) begin
            state_nxt   = READ;
            addr_nxt    = '0;
            pending_nxt = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end else if (toggle) begin
          pending_nxt = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      addr        <= '0;
      pending     <= 1'b0;
      trig_q      <= 1'b0;
      overrun_err <= 1'b0;
      tile_done   <= 1'b0;
      tile_count  <= '0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      pending   <= pending_nxt;
      trig_q    <= output_trigger_in;
      tile_done <= drain_done;
      if (toggle && (state != IDLE)) overrun_err <= 1'b1;
      if (drain_done) tile_count <= tile_count + 16'd1;
    end
  end

  // Read issue -> data return: one valid bit per outstanding SRAM read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_vld_p <= '0;
    end else begin
      rd_vld_p <= (rd_vld_p << 1) | RD_DELAY'(rd_en);
    end
  end

  // Data return -> FIFO -> stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      beat_cnt   <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop) begin
        rd_ptr   <= ptr_inc(rd_ptr);
        beat_cnt <= beat_cnt + ADDR_WTH'(1);
      end
      fifo_count <= fifo_count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.rd_data_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) assert (!(push && !pop && (fifo_count == CNT_W'(FIFO_DEPTH))));
  end

endmodule

// File: tb/tb_c_result_drain.sv
// Self-checking bench for c_result_drain: table of tile drains under varied
// ready patterns, plus hand-written latency, stall, chaining, overrun and reset sequences.
module tb_c_result_drain;
  localparam int D_WIDTH    = 64;
  localparam int ADDR_WTH   = 2;
  localparam int RD_DELAY   = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int TILE       = 1 << ADDR_WTH;

  logic        clk = 1'b0;
  logic        rst;
  logic        output_trigger_in;
  logic        busy, tile_done, overrun_err;
  logic [15:0] tile_count;

  c_result_drain_if #(.D_WIDTH(D_WIDTH), .ADDR_WTH(ADDR_WTH)) bus ();

  c_result_drain #(
    .D_WIDTH(D_WIDTH), .ADDR_WTH(ADDR_WTH), .RD_DELAY(RD_DELAY), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .output_trigger_in(output_trigger_in), .bus(bus),
    .busy(busy), .tile_done(tile_done), .overrun_err(overrun_err), .tile_count(tile_count)
  );

  always #5 clk = ~clk;

  // SRAM model with a two-cycle read latency.
  logic [D_WIDTH-1:0] sram [TILE];
  logic [D_WIDTH-1:0] rd_p1, rd_p2;
  always @(posedge clk) begin
    rd_p1 <= sram[bus.rd_addr_out];
    rd_p2 <= rd_p1;
  end
  assign bus.rd_data_in = rd_p2;

  typedef struct {
    logic [63:0] data;
    logic        last;
  } beat_t;
  beat_t sb_q[$];

  typedef struct {
    logic [7:0]  rdy_pat;
    logic [63:0] base;
    logic [15:0] exp_count;
    logic        exp_ovr;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  task automatic chkv(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, required %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output monitor: scoreboard pops, hold-while-stalled, read address order, credit limit.
  int                  issued = 0;
  int                  accepted = 0;
  int                  tile_done_cnt = 0;
  logic [ADDR_WTH-1:0] exp_addr = '0;
  logic                prev_stall = 1'b0;
  logic [63:0]         prev_data = '0;
  logic                prev_last = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      issued        = 0;
      accepted      = 0;
      tile_done_cnt = 0;
      exp_addr      = '0;
      prev_stall    = 1'b0;
      sb_q.delete();
    end else begin
      if (prev_stall) begin
        chk1("hold_tvalid", bus.m_tvalid, 1'b1);
        chkv("hold_tdata", bus.m_tdata, prev_data);
        chk1("hold_tlast", bus.m_tlast, prev_last);
      end
      if (bus.rd_en_out) begin
        chkv("rd_addr", 64'(bus.rd_addr_out), 64'(exp_addr));
        chk1("rd_credit", (issued - accepted) < FIFO_DEPTH, 1'b1);
        exp_addr = exp_addr + ADDR_WTH'(1);
        issued++;
      end
      if (bus.m_tvalid && bus.m_tready) begin
        chk1("beat_expected", sb_q.size() != 0, 1'b1);
        if (sb_q.size() != 0) begin
          beat_t e;
          e = sb_q.pop_front();
          chkv("tdata", bus.m_tdata, e.data);
          chk1("tlast", bus.m_tlast, e.last);
        end
        accepted++;
      end
      if (tile_done) tile_done_cnt++;
      prev_stall = bus.m_tvalid && !bus.m_tready;
      prev_data  = bus.m_tdata;
      prev_last  = bus.m_tlast;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_tile(input logic [63:0] base);
    for (int i = 0; i < TILE; i++) sram[i] = base + 64'(i);
  endtask

  task automatic expect_tile(input logic [63:0] base);
    for (int i = 0; i < TILE; i++) sb_q.push_back('{data: base + 64'(i), last: (i == TILE - 1)});
  endtask

  task automatic toggle();
    output_trigger_in = ~output_trigger_in;
  endtask

  task automatic run_until(input int target, input logic [7:0] pat, input int budget, input string name);
    int c;
    c = 0;
    while (tile_done_cnt < target && c < budget) begin
      bus.m_tready = pat[c[2:0]];
      tick();
      c++;
    end
    bus.m_tready = 1'b1;
    chk1({name, "_done_in_budget"}, tile_done_cnt >= target, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [5];
    int   exp_tiles;
    int   iss0, acc0, c;

    vecs[0] = '{rdy_pat: 8'hFF, base: 64'hA5A5_0000_0000_0100, exp_count: 16'd2, exp_ovr: 1'b0};
    vecs[1] = '{rdy_pat: 8'h99, base: 64'h0123_4567_89AB_CD00, exp_count: 16'd3, exp_ovr: 1'b0};
    vecs[2] = '{rdy_pat: 8'h55, base: 64'hFFFF_FFFF_FFFF_FF00, exp_count: 16'd4, exp_ovr: 1'b0};
    vecs[3] = '{rdy_pat: 8'h01, base: 64'h8000_0000_0000_0040, exp_count: 16'd5, exp_ovr: 1'b0};
    vecs[4] = '{rdy_pat: 8'hB3, base: 64'h0000_0000_DEAD_0000, exp_count: 16'd6, exp_ovr: 1'b0};

    rst = 1'b1;
    output_trigger_in = 1'b0;
    bus.m_tready = 1'b0;
    load_tile(64'h0);
    repeat (3) tick();

    // Reset state
    chk1("rst_rd_en", bus.rd_en_out, 1'b0);
    chkv("rst_rd_addr", 64'(bus.rd_addr_out), 64'h0);
    chk1("rst_tvalid", bus.m_tvalid, 1'b0);
    chkv("rst_tdata", bus.m_tdata, 64'h0);
    chk1("rst_tlast", bus.m_tlast, 1'b0);
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_tile_done", tile_done, 1'b0);
    chk1("rst_overrun", overrun_err, 1'b0);
    chkv("rst_tile_count", 64'(tile_count), 64'h0);
    rst = 1'b0;
    tick();
    chk1("idle_after_release", busy, 1'b0);

    // Basic drain with exact cycle timing
    load_tile(64'h10);
    expect_tile(64'h10);
    bus.m_tready = 1'b1;
    toggle();
    chk1("basic_rd_en_T0", bus.rd_en_out, 1'b0);
    for (int i = 0; i < TILE; i++) begin
      tick();
      chk1("basic_rd_en", bus.rd_en_out, 1'b1);
      chkv("basic_rd_addr", 64'(bus.rd_addr_out), 64'(i));
      chk1("basic_first_valid", bus.m_tvalid, i == TILE - 1);
    end
    for (int i = 0; i < TILE; i++) begin
      chk1("basic_tvalid_run", bus.m_tvalid, 1'b1);
      chk1("basic_tlast_pos", bus.m_tlast, i == TILE - 1);
      tick();
    end
    chk1("basic_tile_done", tile_done, 1'b1);
    chkv("basic_tile_count", 64'(tile_count), 64'd1);
    chk1("basic_busy_end", busy, 1'b0);
    chk1("basic_tvalid_end", bus.m_tvalid, 1'b0);
    tick();
    chk1("basic_tile_done_pulse", tile_done, 1'b0);
    exp_tiles = 1;

    // Table-driven tile drains under varied ready patterns
    for (int v = 0; v < 5; v++) begin
      load_tile(vecs[v].base);
      expect_tile(vecs[v].base);
      toggle();
      exp_tiles++;
      run_until(exp_tiles, vecs[v].rdy_pat, 200, "vec");
      chkv("vec_tile_count", 64'(tile_count), 64'(vecs[v].exp_count));
      chk1("vec_overrun", overrun_err, vecs[v].exp_ovr);
      chk1("vec_busy", busy, 1'b0);
      chkv("vec_sb_empty", 64'(sb_q.size()), 64'd0);
      tick();
    end

    // Stall from start: four reads fill the credit, then reads stop
    load_tile(64'h5A00_0000_0000_0070);
    expect_tile(64'h5A00_0000_0000_0070);
    bus.m_tready = 1'b0;
    iss0 = issued;
    toggle();
    repeat (20) tick();
    chkv("stall_reads_issued", 64'(issued - iss0), 64'd4);
    chk1("stall_rd_en_low", bus.rd_en_out, 1'b0);
    chk1("stall_tvalid", bus.m_tvalid, 1'b1);
    chkv("stall_head", bus.m_tdata, 64'h5A00_0000_0000_0070);
    chk1("stall_busy", busy, 1'b1);
    exp_tiles++;
    run_until(exp_tiles, 8'hFF, 50, "stall");
    chkv("stall_tile_count", 64'(tile_count), 64'(exp_tiles));

    // Back-to-back: second toggle on the cycle the last beat is accepted
    load_tile(64'h0000_BEEF_0000_0000);
    expect_tile(64'h0000_BEEF_0000_0000);
    bus.m_tready = 1'b1;
    toggle();
    c = 0;
    while (!(bus.m_tvalid && bus.m_tlast) && c < 50) begin
      tick();
      c++;
    end
    chk1("b2b_last_seen", bus.m_tvalid && bus.m_tlast, 1'b1);
    expect_tile(64'h0000_BEEF_0000_0000);
    toggle();
    tick();
    chk1("b2b_tile_done", tile_done, 1'b1);
    chk1("b2b_busy_no_gap", busy, 1'b1);
    chk1("b2b_rd_en_no_gap", bus.rd_en_out, 1'b1);
    chkv("b2b_rd_addr", 64'(bus.rd_addr_out), 64'd0);
    chk1("b2b_overrun", overrun_err, 1'b1);
    exp_tiles += 2;
    run_until(exp_tiles, 8'hFF, 50, "b2b");
    chkv("b2b_tile_count", 64'(tile_count), 64'(exp_tiles));

    // Reset mid-drain after two accepted beats
    load_tile(64'h7777_0000_0000_0010);
    expect_tile(64'h7777_0000_0000_0010);
    toggle();
    acc0 = accepted;
    c = 0;
    while ((accepted - acc0) < 2 && c < 50) begin
      tick();
      c++;
    end
    chkv("rst_mid_two_beats", 64'(accepted - acc0), 64'd2);
    rst = 1'b1;
    output_trigger_in = 1'b0;
    #1;
    chk1("rst_mid_rd_en", bus.rd_en_out, 1'b0);
    chk1("rst_mid_tvalid", bus.m_tvalid, 1'b0);
    chkv("rst_mid_tdata", bus.m_tdata, 64'h0);
    chk1("rst_mid_tlast", bus.m_tlast, 1'b0);
    chk1("rst_mid_busy", busy, 1'b0);
    chk1("rst_mid_overrun", overrun_err, 1'b0);
    chkv("rst_mid_tile_count", 64'(tile_count), 64'h0);
    tick();
    tick();
    rst = 1'b0;
    exp_tiles = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk1("post_rst_no_tvalid", bus.m_tvalid, 1'b0);
      chk1("post_rst_idle", busy, 1'b0);
    end
    load_tile(64'h3300_0000_0000_0020);
    expect_tile(64'h3300_0000_0000_0020);
    toggle();
    exp_tiles = 1;
    run_until(exp_tiles, 8'hFF, 50, "post_rst");
    chkv("post_rst_tile_count", 64'(tile_count), 64'd1);

    // Overrun: two extra toggles during a drain yield exactly one more tile
    chk1("ovr_clear_before", overrun_err, 1'b0);
    load_tile(64'h0F0F_0000_0000_00A0);
    expect_tile(64'h0F0F_0000_0000_00A0);
    toggle();
    tick();
    tick();
    chk1("ovr_busy", busy, 1'b1);
    expect_tile(64'h0F0F_0000_0000_00A0);
    toggle();
    tick();
    toggle();
    chk1("ovr_set", overrun_err, 1'b1);
    exp_tiles += 2;
    run_until(exp_tiles, 8'hFF, 80, "ovr");
    repeat (20) tick();
    chkv("ovr_tile_count", 64'(tile_count), 64'(exp_tiles));
    chk1("ovr_idle", busy, 1'b0);
    chkv("ovr_sb_empty", 64'(sb_q.size()), 64'd0);
    chk1("ovr_sticky", overrun_err, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/c_result_drain.md
Name: c_result_drain

Overview:
- Downstream consumer of the double-buffered C result store.
- Watches the store-side buffer-swap indication (output_trigger). Each toggle means one C tile buffer is complete and readable.
- On each toggle, reads every word of the completed buffer through the result read port, which has a fixed read latency.
- Emits the words as a valid/ready stream with last-beat marking. Backpressure is absorbed by a credit-controlled output FIFO.

Parameters:
- D_WIDTH, 64, result word width.
- ADDR_WTH, 2, result buffer address width; a tile is 2^ADDR_WTH words.
- RD_DELAY, 2, cycles from rd_en_out high to rd_data_in valid; must match the SRAM.
- FIFO_DEPTH, 4, output FIFO entries; must be >= RD_DELAY+1.

Ports:
- clk  input  1  clock; also drives the result store's read clock.
- rst  input  1  asynchronous, active-high reset.
- output_trigger_in  input  1  buffer-swap level from the result store; each toggle marks a completed tile.
- rd_en_out  output  1  read enable to the result buffer.
- rd_addr_out  output  ADDR_WTH  read address.
- rd_data_in  input  D_WIDTH  read data, valid RD_DELAY cycles after rd_en_out.
- m_tdata  output  D_WIDTH  stream data.
- m_tvalid  output  1  stream valid.
- m_tready  input  1  stream ready.
- m_tlast  output  1  high on the final word of a tile.
- busy  output  1  high while not IDLE.
- tile_done  output  1  one-cycle pulse when a tile has fully drained.
- overrun_err  output  1  sticky; a toggle arrived while busy.
- tile_count  output  16  completed tiles, wraps modulo 2^16.

Behaviour:
- Reset values:
  - All outputs 0.
  - trig_q is 0, matching the store index reset value.
  - State IDLE; FIFO empty; in-flight count 0.
- Toggle detect: toggle = output_trigger_in ^ trig_q. trig_q is updated every cycle.
- IDLE:
  - On toggle, move to READ at the next edge and set the address to 0.
  - Otherwise stay in IDLE.
- READ:
  - rd_en_out = (fifo_count + inflight < FIFO_DEPTH). This is combinational from registers.
  - rd_addr_out = the current read address.
  - Each cycle with rd_en_out high, the address increments.
  - When the issued address is all-ones, the next state is FLUSH.
- In-flight tracking:
  - A RD_DELAY-deep valid shift register tracks issued reads.
  - When a valid emerges from it, rd_data_in is written into the FIFO at that edge.
  - inflight = popcount of the shift register.
  - FIFO overflow is impossible by construction; assert on it in simulation.
- Stream output:
  - m_tvalid = FIFO not empty; m_tdata = FIFO head.
  - A pop happens on m_tvalid && m_tready.
  - m_tlast = the head word's index equals 2^ADDR_WTH-1. The index is tracked by a popped-beat counter that resets per tile.
- FLUSH:
  - Wait for the beat with m_tlast to be accepted.
  - On that edge: pulse tile_done, increment tile_count, return to IDLE.
- Latency:
  - First rd_en_out occurs in the cycle after the toggle is detected.
  - First m_tvalid occurs RD_DELAY+1 cycles after the first rd_en_out.
  - With m_tready held high, throughput is 1 word/cycle.
  - A 4-word tile (RD_DELAY=2) completes in 1+4+3 = 8 cycles from toggle detection to the last beat.
- Toggle while busy:
  - Set overrun_err (sticky until rst) and set pending.
  - The current drain completes unchanged.
  - On the edge returning to IDLE, pending causes an immediate transition to READ; pending clears.
  - A second toggle while pending is already set is lost (still reported via overrun_err).
- Simultaneous toggle and drain completion: treated as pending, so there is no gap cycle.
- Reset mid-operation:
  - Everything clears immediately.
  - In-flight read data arriving after reset is discarded.
  - trig_q is cleared, so an output_trigger_in level of 1 at reset release counts as a toggle.
- Address wrap: after the all-ones address the address counter wraps to 0 and is not reused until the next tile.
- m_tdata, m_tlast and m_tvalid must hold stable while m_tvalid && !m_tready.

Test Plan:
- Basic drain:
  - Stimulus: SRAM model with RD_DELAY=2, words 0x10..0x13; toggle output_trigger_in 0->1; m_tready=1.
  - Required: rd_addr 0,1,2,3 on consecutive cycles; m_tdata 0x10..0x13 on consecutive cycles; m_tlast on 0x13; tile_done pulse; tile_count=1.
- Backpressure:
  - Stimulus: as above with m_tready toggling 1,0,0,1,...
  - Required: all 4 words in order, no duplicates; rd_en_out drops whenever fifo_count+inflight reaches 4; data held stable while stalled.
- Stall from start:
  - Stimulus: m_tready=0 for 20 cycles, then 1.
  - Required: exactly 4 reads issued, then rd_en_out stays 0; all 4 words delivered once ready rises.
- Back-to-back tiles:
  - Stimulus: second toggle (1->0) on the cycle the first tile's last beat is accepted.
  - Required: second tile drained with no idle cycle; tile_count=2; overrun_err=1.
- Overrun:
  - Stimulus: two extra toggles during a drain.
  - Required: overrun_err=1, sticky; exactly one additional tile drained.
- Reset mid-drain:
  - Stimulus: rst asserted after 2 beats.
  - Required: outputs 0 immediately; no stray m_tvalid after release; next toggle drains a full 4-word tile correctly.
